// File: rtl/coax_pkg.sv
// Shared coax definitions: FSM state encodings, default timing constants and
// small helpers used to derive cycle counts and timer width.
package coax_pkg;

    typedef enum logic [2:0] {
        STATE_IDLE       = 3'd0,
        STATE_TX_START   = 3'd1,
        STATE_TX         = 3'd2,
        STATE_TURNAROUND = 3'd3,
        STATE_RX_WAIT    = 3'd4,
        STATE_RX_ACTIVE  = 3'd5
    } coax_state_t;

    localparam int DEF_CLOCKS_PER_BIT        = 8;
    localparam int DEF_TURNAROUND_BITS       = 2;
    localparam int DEF_RESPONSE_TIMEOUT_BITS = 8;
    localparam int DEF_TX_START_BITS         = 2;

    localparam int DEF_TX_START_CYCLES   = DEF_TX_START_BITS * DEF_CLOCKS_PER_BIT;
    localparam int DEF_TURNAROUND_CYCLES = DEF_TURNAROUND_BITS * DEF_CLOCKS_PER_BIT;
    localparam int DEF_RESPONSE_CYCLES   = DEF_RESPONSE_TIMEOUT_BITS * DEF_CLOCKS_PER_BIT;

    function automatic int cycles_for(input int bits, input int clocks_per_bit);
        return bits * clocks_per_bit;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // One extra bit over the largest load so the full count is representable.
    function automatic int timer_width(input int max_load);
        return $clog2(max_load) + 1;
    endfunction

    function automatic logic tx_en_of(input coax_state_t s);
        return (s == STATE_TX_START) || (s == STATE_TX);
    endfunction

    function automatic logic rx_en_of(input coax_state_t s);
        return (s == STATE_IDLE) || (s == STATE_RX_WAIT) || (s == STATE_RX_ACTIVE);
    endfunction

endpackage

// File: rtl/coax_bit_timer.sv
// Loadable saturating down-counter; expired marks the last cycle of a loaded
// interval so the owning state lasts exactly load_value cycles.
module coax_bit_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == W'(1));

endmodule

// File: rtl/coax_line_ctrl.sv
// Half-duplex coax line controller: arbitrates host transmit requests against
// receive activity, sequences turnaround and bounds the wait for a response.
module coax_line_ctrl
    import coax_pkg::*;
#(
    parameter int CLOCKS_PER_BIT        = DEF_CLOCKS_PER_BIT,
    parameter int TURNAROUND_BITS       = DEF_TURNAROUND_BITS,
    parameter int RESPONSE_TIMEOUT_BITS = DEF_RESPONSE_TIMEOUT_BITS,
    parameter int TX_START_BITS         = DEF_TX_START_BITS
) (
    input  logic clk,
    input  logic reset,
    input  logic host_tx_req,
    input  logic host_expect_response,
    output logic host_tx_ack,
    output logic tx_enable,
    input  logic tx_active,
    output logic rx_enable,
    input  logic rx_active,
    output logic line_busy,
    output logic response_done,
    output logic response_timeout,
    output logic tx_fault
);

    localparam int TX_START_CYCLES   = cycles_for(TX_START_BITS, CLOCKS_PER_BIT);
    localparam int TURNAROUND_CYCLES = cycles_for(TURNAROUND_BITS, CLOCKS_PER_BIT);
    localparam int RESPONSE_CYCLES   = cycles_for(RESPONSE_TIMEOUT_BITS, CLOCKS_PER_BIT);
    localparam int TW = timer_width(max3(TX_START_CYCLES, TURNAROUND_CYCLES, RESPONSE_CYCLES));

    coax_state_t   state, state_nx;
    logic          expect_q, expect_nx;
    logic          tx_prev, rx_prev;
    logic          timer_load;
    logic [TW-1:0] timer_value;
    logic          timer_expired;
    logic          ack_nx, done_nx, timeout_nx, fault_nx;

    coax_bit_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .expired    (timer_expired)
    );

    always_comb begin
        state_nx    = state;
        expect_nx   = expect_q;
        timer_load  = 1'b0;
        timer_value = '0;
        ack_nx      = 1'b0;
        done_nx     = 1'b0;
        timeout_nx  = 1'b0;
        fault_nx    = 1'b0;
        case (state)
            STATE_IDLE: begin
                // Receive activity takes priority; the request stays pending.
                if (host_tx_req && !rx_active) begin
                    ack_nx      = 1'b1;
                    expect_nx   = host_expect_response;
                    state_nx    = STATE_TX_START;
                    timer_load  = 1'b1;
                    timer_value = TW'(TX_START_CYCLES);
                end
            end
            STATE_TX_START: begin
                if (tx_active) begin
                    state_nx = STATE_TX;
                end else if (timer_expired) begin
                    fault_nx = 1'b1;
                    state_nx = STATE_IDLE;
                end
            end
            STATE_TX: begin
                if (tx_prev && !tx_active) begin
                    state_nx    = STATE_TURNAROUND;
                    timer_load  = 1'b1;
                    timer_value = TW'(TURNAROUND_CYCLES);
                end
            end
            STATE_TURNAROUND: begin
                if (timer_expired) begin
                    if (expect_q) begin
                        state_nx    = STATE_RX_WAIT;
                        timer_load  = 1'b1;
                        timer_value = TW'(RESPONSE_CYCLES);
                    end else begin
                        state_nx = STATE_IDLE;
                    end
                end
            end
            STATE_RX_WAIT: begin
                // A response starting on the expiry cycle still counts.
                if (rx_active) begin
                    state_nx = STATE_RX_ACTIVE;
                end else if (timer_expired) begin
                    timeout_nx = 1'b1;
                    state_nx   = STATE_IDLE;
                end
            end
            STATE_RX_ACTIVE: begin
                if (rx_prev && !rx_active) begin
                    done_nx  = 1'b1;
                    state_nx = STATE_IDLE;
                end
            end
            default: begin
                state_nx = STATE_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they track the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= STATE_IDLE;
            expect_q         <= 1'b0;
            tx_prev          <= 1'b0;
            rx_prev          <= 1'b0;
            host_tx_ack      <= 1'b0;
            tx_enable        <= 1'b0;
            rx_enable        <= 1'b0;
            line_busy        <= 1'b0;
            response_done    <= 1'b0;
            response_timeout <= 1'b0;
            tx_fault         <= 1'b0;
        end else begin
            state            <= state_nx;
            expect_q         <= expect_nx;
            tx_prev          <= tx_active;
            rx_prev          <= rx_active;
            host_tx_ack      <= ack_nx;
            tx_enable        <= tx_en_of(state_nx);
            rx_enable        <= rx_en_of(state_nx);
            line_busy        <= (state_nx != STATE_IDLE);
            response_done    <= done_nx;
            response_timeout <= timeout_nx;
            tx_fault         <= fault_nx;
        end
    end

endmodule

// File: tb/tb_coax_line_ctrl.sv
// Directed bench for coax_line_ctrl with hand-computed cycle counts at the
// default timing (8 clocks/bit, 2-bit turnaround, 8-bit response window).
module tb_coax_line_ctrl;
    import coax_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic host_tx_req;
    logic host_expect_response;
    logic host_tx_ack;
    logic tx_enable;
    logic tx_active;
    logic rx_enable;
    logic rx_active;
    logic line_busy;
    logic response_done;
    logic response_timeout;
    logic tx_fault;

    int n_checks = 0;
    int n_pass   = 0;
    int n_ack = 0, n_done = 0, n_timeout = 0, n_fault = 0, n_overlap = 0;

    coax_line_ctrl dut (
        .clk                  (clk),
        .reset                (reset),
        .host_tx_req          (host_tx_req),
        .host_expect_response (host_expect_response),
        .host_tx_ack          (host_tx_ack),
        .tx_enable            (tx_enable),
        .tx_active            (tx_active),
        .rx_enable            (rx_enable),
        .rx_active            (rx_active),
        .line_busy            (line_busy),
        .response_done        (response_done),
        .response_timeout     (response_timeout),
        .tx_fault             (tx_fault)
    );

    always #5 clk = ~clk;

    // Pulse tallies and enable-exclusivity monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (host_tx_ack)      n_ack++;
        if (response_done)    n_done++;
        if (response_timeout) n_timeout++;
        if (tx_fault)         n_fault++;
        if (tx_enable && rx_enable) begin
            n_overlap++;
            $display("FAIL enable_overlap: tx_enable and rx_enable both 1 at %0t", $time);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int max, output int n);
        n = 0;
        while (dut.state != s && n < max) begin
            tick();
            n++;
        end
        check(tag, dut.state, s);
    endtask

    task automatic count_until_leave(input logic [2:0] s, input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (dut.state == s && n < max);
    endtask

    task automatic run_frame(input logic exp, input int len);
        host_tx_req          = 1'b1;
        host_expect_response = exp;
        tick();
        check("frame_ack", host_tx_ack, 1);
        host_tx_req = 1'b0;
        tx_active   = 1'b1;
        repeat (len) tick();
        tx_active = 1'b0;
        tick();
        check("frame_turnaround_entry", dut.state, STATE_TURNAROUND);
    endtask

    initial begin
        int n;
        int base;
        reset = 1'b1;
        host_tx_req = 1'b0;
        host_expect_response = 1'b0;
        tx_active = 1'b0;
        rx_active = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_state", dut.state, STATE_IDLE);
        check("rst_rx_enable", rx_enable, 0);
        check("rst_tx_enable", tx_enable, 0);
        check("rst_line_busy", line_busy, 0);
        check("rst_timer", dut.u_timer.count, 0);
        check("rst_expect", dut.expect_q, 0);
        reset = 1'b0;
        check("rx_enable_before_edge", rx_enable, 0);
        tick();
        check("rx_enable_after_edge", rx_enable, 1);

        // Transmit without response
        host_tx_req = 1'b1;
        host_expect_response = 1'b0;
        tick();
        check("a_ack", host_tx_ack, 1);
        check("a_state_tx_start", dut.state, STATE_TX_START);
        check("a_tx_enable", tx_enable, 1);
        check("a_rx_enable", rx_enable, 0);
        check("a_busy", line_busy, 1);
        host_tx_req = 1'b0;
        tx_active = 1'b1;
        repeat (96) tick();
        check("a_state_tx", dut.state, STATE_TX);
        tx_active = 1'b0;
        tick();
        check("a_turnaround", dut.state, STATE_TURNAROUND);
        check("a_turn_tx_en", tx_enable, 0);
        check("a_turn_rx_en", rx_enable, 0);
        count_until_leave(STATE_TURNAROUND, 40, n);
        check("a_turnaround_len", n, 16);
        check("a_idle", dut.state, STATE_IDLE);
        check("a_idle_rx_en", rx_enable, 1);
        check("a_idle_busy", line_busy, 0);

        // Response received after 40 cycles in RX_WAIT
        run_frame(1'b1, 20);
        wait_state("b_rx_wait", STATE_RX_WAIT, 40, n);
        check("b_turn_len", n, 16);
        check("b_rx_en", rx_enable, 1);
        base = n_timeout;
        n = n_done;
        repeat (39) tick();
        rx_active = 1'b1;
        tick();
        check("b_rx_active", dut.state, STATE_RX_ACTIVE);
        repeat (119) tick();
        check("b_still_rx_active", dut.state, STATE_RX_ACTIVE);
        rx_active = 1'b0;
        tick();
        check("b_done_pulse", response_done, 1);
        check("b_idle", dut.state, STATE_IDLE);
        tick();
        check("b_done_one_cycle", response_done, 0);
        check("b_done_count", n_done - n, 1);
        check("b_no_timeout", n_timeout - base, 0);

        // Response timeout
        run_frame(1'b1, 10);
        wait_state("c_rx_wait", STATE_RX_WAIT, 40, n);
        base = n_timeout;
        n = 0;
        while (!response_timeout && n < 100) begin
            tick();
            n++;
        end
        check("c_timeout_latency", n, 64);
        check("c_idle", dut.state, STATE_IDLE);
        tick();
        check("c_timeout_one_cycle", response_timeout, 0);
        check("c_timeout_count", n_timeout - base, 1);

        // Response starting on the expiry cycle wins
        run_frame(1'b1, 5);
        wait_state("d_rx_wait", STATE_RX_WAIT, 40, n);
        base = n_timeout;
        repeat (63) tick();
        check("d_still_wait", dut.state, STATE_RX_WAIT);
        rx_active = 1'b1;
        tick();
        check("d_rx_active", dut.state, STATE_RX_ACTIVE);
        check("d_no_timeout_pulse", response_timeout, 0);
        rx_active = 1'b0;
        tick();
        check("d_done", response_done, 1);
        check("d_no_timeout_count", n_timeout - base, 0);

        // Receive wins a same-cycle tie; then transmitter never starts
        base = n_ack;
        rx_active = 1'b1;
        host_tx_req = 1'b1;
        host_expect_response = 1'b0;
        repeat (5) tick();
        check("e_no_ack", host_tx_ack, 0);
        check("e_no_ack_count", n_ack - base, 0);
        check("e_idle", dut.state, STATE_IDLE);
        rx_active = 1'b0;
        tick();
        check("e_ack_after_rx", host_tx_ack, 1);
        host_tx_req = 1'b0;
        base = n_fault;
        n = 0;
        while (!tx_fault && n < 40) begin
            tick();
            n++;
        end
        check("e_fault_latency", n, 16);
        check("e_fault_idle", dut.state, STATE_IDLE);
        tick();
        check("e_fault_one_cycle", tx_fault, 0);
        check("e_fault_count", n_fault - base, 1);

        // Reset asserted mid-TX
        host_tx_req = 1'b1;
        tick();
        host_tx_req = 1'b0;
        tx_active = 1'b1;
        repeat (5) tick();
        check("f_in_tx", dut.state, STATE_TX);
        check("f_tx_en", tx_enable, 1);
        base = n_done + n_timeout + n_fault + n_ack;
        #2;
        reset = 1'b1;
        #1;
        check("f_tx_en_async", tx_enable, 0);
        check("f_rx_en_async", rx_enable, 0);
        check("f_state_idle", dut.state, STATE_IDLE);
        tx_active = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check("f_no_pulses", n_done + n_timeout + n_fault + n_ack - base, 0);
        tick();
        check("f_rx_en_back", rx_enable, 1);
        check("f_idle_after", dut.state, STATE_IDLE);

        check("enable_overlap_total", n_overlap, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/coax_line_ctrl.md
COAX_LINE_CTRL -- requirements
Module: coax_line_ctrl

Interface
REQ-001 Parameter: CLOCKS_PER_BIT, 8, clock cycles per coax bit time.
REQ-002 Parameter: TURNAROUND_BITS, 2, line-quiet bit times between end of transmit and enabling receive.
REQ-003 Parameter: RESPONSE_TIMEOUT_BITS, 8, bit times to wait for a response to start before declaring timeout.
REQ-004 Parameter: TX_START_BITS, 2, bit times allowed for tx_active to rise after tx_enable.
REQ-005 Port: clk  in  1  system clock; all logic is on the rising edge.
REQ-006 Port: reset  in  1  asynchronous, active-high reset.
REQ-007 Port: host_tx_req  in  1  level; host requests to transmit a frame.
REQ-008 Port: host_expect_response  in  1  sampled when the request is accepted; 1 means a response is expected.
REQ-009 Port: host_tx_ack  out  1  one-cycle pulse; request accepted.
REQ-010 Port: tx_enable  out  1  gates the transmitter.
REQ-011 Port: tx_active  in  1  transmitter is driving the line.
REQ-012 Port: rx_enable  out  1  gates the receiver; 0 holds it idle.
REQ-013 Port: rx_active  in  1  receiver is inside a frame.
REQ-014 Port: line_busy  out  1  1 in every state except IDLE.
REQ-015 Port: response_done  out  1  one-cycle pulse; the expected response frame has ended.
REQ-016 Port: response_timeout  out  1  one-cycle pulse; no response started in time.
REQ-017 Port: tx_fault  out  1  one-cycle pulse; the transmitter never started.

Function
REQ-018 FSM states: IDLE, TX_START, TX, TURNAROUND, RX_WAIT, RX_ACTIVE.
REQ-019 All outputs are registered, and every output is a pure function of the state except the pulse outputs.
REQ-020 rx_enable=1 in IDLE, RX_WAIT and RX_ACTIVE; tx_enable=1 in TX_START and TX only; the two are never 1 in the same cycle.
REQ-021 IDLE: if host_tx_req=1 and rx_active=0, the controller pulses host_tx_ack, latches host_expect_response and enters TX_START on the next cycle.
REQ-022 IDLE: if rx_active=1, host_tx_req is not acknowledged; the receive side wins a same-cycle tie, and the request stays pending while the host holds it.
REQ-023 TX_START: tx_active=1 moves to TX; if TX_START_BITS*CLOCKS_PER_BIT cycles elapse with tx_active=0, the controller pulses tx_fault and returns to IDLE.
REQ-024 TX: the falling edge of tx_active moves to TURNAROUND, and the bit timer is loaded with TURNAROUND_BITS*CLOCKS_PER_BIT.
REQ-025 TURNAROUND: both enables are 0; on timer expiry the controller goes to RX_WAIT if the latched expect bit is 1, else to IDLE.
REQ-026 RX_WAIT: the timer is loaded with RESPONSE_TIMEOUT_BITS*CLOCKS_PER_BIT; rx_active=1 moves to RX_ACTIVE; on expiry the controller pulses response_timeout and goes to IDLE.
REQ-027 rx_active rising in the same cycle as timer expiry counts as a response: RX_ACTIVE, no timeout.
REQ-028 RX_ACTIVE: there is no timeout; the falling edge of rx_active pulses response_done and moves to IDLE.
REQ-029 host_tx_req is ignored in every state except IDLE; at most one host_tx_ack is issued per IDLE entry.
REQ-030 The timer width is $clog2 of the largest load value plus 1; the timer saturates at 0 and never wraps.
REQ-031 A state lasts exactly its loaded count in cycles, measured from entry to the transition edge.

Reset
REQ-032 While reset=1: state=IDLE, timer=0, latched expect bit=0, and all outputs=0, including rx_enable.
REQ-033 rx_enable rises on the first clock edge after reset deasserts.
REQ-034 Reset asserted mid-frame drops tx_enable and rx_enable immediately (asynchronously) and emits no pulse outputs.

Structure
REQ-035 The state encodings and the derived cycle-count constants live in a shared coax header so that testbenches can reference them as dut.STATE_*.
REQ-036 The down-counter is a sub-module, coax_bit_timer, with ports: load, load_value, expired.

Verification
REQ-037 Test (CLOCKS_PER_BIT=8, TURNAROUND_BITS=2, RESPONSE_TIMEOUT_BITS=8). Stimulus: req with expect=0; tx_active high for 96 cycles. Required: ack after 1 cycle; TURNAROUND lasts 16 cycles; then IDLE with rx_enable=1.
REQ-038 Test. Stimulus: req with expect=1; rx_active rises 40 cycles into RX_WAIT and stays high 120 cycles. Required: one response_done pulse; state IDLE; no timeout.
REQ-039 Test. Stimulus: req with expect=1; rx_active held 0. Required: response_timeout pulses exactly 64 cycles after RX_WAIT entry; then IDLE.
REQ-040 Test. Stimulus: rx_active=1 and host_tx_req=1 in the same cycle. Required: no ack until rx_active falls; ack on the following cycle.
REQ-041 Test. Stimulus: req with tx_active held 0. Required: tx_fault pulse after 16 cycles; then IDLE.
REQ-042 Test. Stimulus: reset asserted mid-TX. Required: tx_enable=0 in the same timestep; state IDLE; no pulse outputs.
